// File: rtl/mem_stage_if.sv
// M-stage inputs and W-stage outputs of the pipeline memory stage, bundled.
// The slave modport is the memory stage; the master modport is the EX/MEM side.
interface mem_stage_if;
  logic [31:0] pc_four_M;
  logic [31:0] instr_M;
  logic        rd_wren_M;
  logic        mem_wren_M;
  logic        insn_vld_M;
  logic [31:0] alu_data_M;
  logic [31:0] rs2_data_M;
  logic [1:0]  wb_sel_M;
  logic [4:0]  rd_addr_M;

  logic [31:0] pc_four_W;
  logic [31:0] alu_data_W;
  logic [31:0] ld_data_W;
  logic        rd_wren_W;
  logic        insn_vld_W;
  logic [1:0]  wb_sel_W;
  logic [4:0]  rd_addr_W;
  logic        misalign_W;

  modport master (
    output pc_four_M, instr_M, rd_wren_M, mem_wren_M, insn_vld_M,
           alu_data_M, rs2_data_M, wb_sel_M, rd_addr_M,
    input  pc_four_W, alu_data_W, ld_data_W, rd_wren_W, insn_vld_W,
           wb_sel_W, rd_addr_W, misalign_W
  );

  modport slave (
    input  pc_four_M, instr_M, rd_wren_M, mem_wren_M, insn_vld_M,
           alu_data_M, rs2_data_M, wb_sel_M, rd_addr_M,
    output pc_four_W, alu_data_W, ld_data_W, rd_wren_W, insn_vld_W,
           wb_sel_W, rd_addr_W, misalign_W
  );
endinterface

// File: rtl/mem_stage.sv
// Memory stage of the 5-stage RV32I pipeline: data memory, LED/switch I/O,
// and the MEM/WB register with combinational load extraction in W.
module mem_stage #(
  parameter int unsigned DMEM_DEPTH_W = 512,
  parameter logic [31:0] LEDR_ADDR    = 32'h1000_0000,
  parameter logic [31:0] SW_ADDR      = 32'h1001_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  mem_stage_if.slave  bus,
  input  logic [31:0] i_io_sw,
  output logic [31:0] o_io_ledr
);
  localparam int          IDX_W      = $clog2(DMEM_DEPTH_W);
  localparam logic [31:0] DMEM_BYTES = 32'(DMEM_DEPTH_W * 4);

  typedef enum logic [1:0] {RGN_NONE, RGN_DMEM, RGN_LEDR, RGN_SW} region_e;

  logic [2:0]       funct3;
  logic [1:0]       off;
  logic [IDX_W-1:0] idx;
  region_e          region;
  logic             misaligned;
  logic [3:0]       byte_en;
  logic [31:0]      st_data;
  logic             store_en;

  logic [31:0] dmem [DMEM_DEPTH_W];
  logic [31:0] dmem_rd;

  logic [2:0]  f3_W;
  logic [1:0]  off_W;
  region_e     region_W;
  logic        lmis_W;
  logic [31:0] io_rd_W;

  logic [31:0] word_W;
  logic [31:0] lane_W;
  logic [31:0] ld_data;

  logic unused_instr;
  assign unused_instr = ^{bus.instr_M[31:15], bus.instr_M[11:0]};

  always_comb begin
    funct3  = bus.instr_M[14:12];
    off     = bus.alu_data_M[1:0];
    idx     = bus.alu_data_M[2 +: IDX_W];
    region  = RGN_NONE;
    if (bus.alu_data_M < DMEM_BYTES)
      region = RGN_DMEM;
    else if (bus.alu_data_M[31:2] == LEDR_ADDR[31:2])
      region = RGN_LEDR;
    else if (bus.alu_data_M[31:2] == SW_ADDR[31:2])
      region = RGN_SW;

    // funct3[1:0] gives the access size for both signed and unsigned loads
    misaligned = 1'b0;
    case (funct3[1:0])
      2'b01:   misaligned = off[0];
      2'b10:   misaligned = (off != 2'b00);
      default: misaligned = 1'b0;
    endcase

    byte_en = 4'b0000;
    case (funct3)
      3'b000:  byte_en = 4'b0001 << off;
      3'b001:  byte_en = 4'b0011 << off;
      3'b010:  byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase

    st_data  = bus.rs2_data_M << {off, 3'b000};
    store_en = bus.mem_wren_M & bus.insn_vld_M & ~misaligned & (byte_en != 4'b0000);
  end

  // Memory is not reset, but writes are blocked while reset is held
  always_ff @(posedge i_clk) begin
    if (i_rst_n && store_en && region == RGN_DMEM) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) dmem[idx][8*b +: 8] <= st_data[8*b +: 8];
      end
    end
    dmem_rd <= dmem[idx];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.pc_four_W  <= '0;
      bus.alu_data_W <= '0;
      bus.rd_wren_W  <= 1'b0;
      bus.insn_vld_W <= 1'b0;
      bus.wb_sel_W   <= 2'b00;
      bus.rd_addr_W  <= '0;
      bus.misalign_W <= 1'b0;
      f3_W           <= '0;
      off_W          <= '0;
      region_W       <= RGN_NONE;
      lmis_W         <= 1'b0;
      io_rd_W        <= '0;
      o_io_ledr      <= '0;
    end else begin
      bus.pc_four_W  <= bus.pc_four_M;
      bus.alu_data_W <= bus.alu_data_M;
      bus.rd_wren_W  <= bus.rd_wren_M;
      bus.insn_vld_W <= bus.insn_vld_M;
      bus.wb_sel_W   <= bus.wb_sel_M;
      bus.rd_addr_W  <= bus.rd_addr_M;
      bus.misalign_W <= bus.insn_vld_M & (bus.mem_wren_M | (bus.wb_sel_M == 2'b01)) & misaligned;
      f3_W           <= funct3;
      off_W          <= off;
      region_W       <= region;
      lmis_W         <= misaligned;
      io_rd_W        <= (region == RGN_SW) ? i_io_sw : o_io_ledr;
      if (store_en && region == RGN_LEDR) begin
        for (int b = 0; b < 4; b++) begin
          if (byte_en[b]) o_io_ledr[8*b +: 8] <= st_data[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    word_W  = (region_W == RGN_DMEM) ? dmem_rd : io_rd_W;
    lane_W  = word_W >> {off_W, 3'b000};
    ld_data = '0;
    case (f3_W)
      3'b000:  ld_data = {{24{lane_W[7]}}, lane_W[7:0]};
      3'b100:  ld_data = {24'h0, lane_W[7:0]};
      3'b001:  ld_data = {{16{lane_W[15]}}, lane_W[15:0]};
      3'b101:  ld_data = {16'h0, lane_W[15:0]};
      3'b010:  ld_data = word_W;
      default: ld_data = '0;
    endcase
    if (bus.wb_sel_W != 2'b01 || lmis_W || region_W == RGN_NONE)
      ld_data = '0;
  end

  assign bus.ld_data_W = ld_data;
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the non-forwarding 5-stage RV32I pipeline. Sits directly downstream of the EX/MEM register and consumes its M-stage outputs.
- Performs loads and stores against an internal synchronous-read data memory and a small memory-mapped I/O window.
- Registers all writeback-relevant fields into W-stage outputs, acting as the MEM/WB boundary. Load data therefore appears exactly one cycle after the load is in M.

Parameters:
DMEM_DEPTH_W, 512, data memory depth in 32-bit words (2 KiB); the address index is log2(DMEM_DEPTH_W) bits wide.
LEDR_ADDR, 32'h1000_0000, word address of the read/write LED register.
SW_ADDR, 32'h1001_0000, word address of the read-only switch input.

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
pc_four_M  in  32  PC+4 of the M-stage instruction
instr_M  in  32  M-stage instruction; funct3 = instr_M[14:12]
rd_wren_M  in  1  register-file write enable
mem_wren_M  in  1  store request
insn_vld_M  in  1  instruction valid (0 = bubble)
alu_data_M  in  32  effective address / ALU result
rs2_data_M  in  32  store data
wb_sel_M  in  2  00 ALU, 01 load, 10 PC+4
rd_addr_M  in  5  destination register
i_io_sw  in  32  switch inputs
pc_four_W, alu_data_W, ld_data_W  out  32 each  W-stage values
rd_wren_W, insn_vld_W  out  1 each
wb_sel_W  out  2
rd_addr_W  out  5
misalign_W  out  1  M-stage access was misaligned
o_io_ledr  out  32  LED register

Behaviour:
- Reset (async, i_rst_n=0): all W outputs, misalign_W and o_io_ledr go to 0 immediately. Data memory contents are not reset.
- Pass-through fields: pc_four, alu_data, rd_wren, insn_vld, wb_sel and rd_addr are registered M->W unchanged every cycle (latency 1).
- Region decode on alu_data_M:
  - DMEM when address < DMEM_DEPTH_W*4.
  - LEDR when alu_data_M[31:2] == LEDR_ADDR[31:2].
  - SW when alu_data_M[31:2] == SW_ADDR[31:2].
  - Any other address is unmapped.
- Offset: off = alu_data_M[1:0].
- Misalignment:
  - Halfword access is misaligned when off[0] = 1.
  - Word access is misaligned when off != 0.
  - Byte access is never misaligned.
- Store: performed only when mem_wren_M & insn_vld_M & ~misaligned.
  - funct3 000 = SB, 001 = SH, 010 = SW.
  - Data is lane-shifted by off and written with byte enables (SB: 1 lane, SH: 2 lanes, SW: 4 lanes) at the posedge.
  - DMEM: write to word index alu_data_M[2+:idx].
  - LEDR: byte-enabled write to o_io_ledr.
  - SW or unmapped: no effect.
  - Any other funct3: no write.
- Load: a read is issued every cycle; the result is only meaningful when wb_sel_M == 01.
  - DMEM read is synchronous: the word is read at the posedge.
  - funct3, off and region are registered alongside so that extraction is combinational in W.
  - funct3 000 LB, 100 LBU: byte at lane off.
  - funct3 001 LH, 101 LHU: halfword at lanes off, off+1.
  - funct3 010 LW: full word.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - LEDR reads o_io_ledr; SW reads i_io_sw sampled at the posedge.
  - ld_data_W = 0 for unmapped addresses, misaligned loads, other funct3, or wb_sel_W != 01.
- misalign_W = registered (insn_vld_M & (mem_wren_M | wb_sel_M == 01) & misaligned).
- Ordering: a store in cycle N followed by a load to the same word in cycle N+1 returns the newly stored data. The write commits at edge N, before the read at edge N+1.
- Bubble: insn_vld_M = 0 suppresses stores. W fields are still registered as presented.
- Reset mid-operation: any store in flight at assertion is dropped. After release, W outputs remain 0 until the first clock edge.

Test Plan:
- Reset: hold i_rst_n=0 with random inputs -> all W outputs and o_io_ledr = 0. Release, present wb_sel_M=00, alu_data_M=32'h1234 -> alu_data_W = 32'h1234 one cycle later.
- SW then LW: SW rs2=32'hDEADBEEF to addr 0x40, next cycle LW 0x40 -> ld_data_W = 32'hDEADBEEF on the following cycle.
- Sub-word stores and loads on word 0x40 = 32'hDEADBEEF:
  - SB 32'h000000A5 to 0x41, then LW 0x40 -> 32'hDEADA5EF.
  - LB 0x41 -> 32'hFFFFFFA5; LBU 0x41 -> 32'h000000A5.
  - LH 0x42 -> 32'hFFFFDEAD; LHU 0x42 -> 32'h0000DEAD.
- Misaligned: SW to 0x42 -> memory unchanged and misalign_W = 1. LH at 0x43 -> ld_data_W = 0 and misalign_W = 1.
- I/O:
  - SW 32'h0000_00FF to LEDR_ADDR -> o_io_ledr = 32'hFF after the edge.
  - SB 32'h12 to LEDR_ADDR+1 -> o_io_ledr = 32'h12FF.
  - i_io_sw = 32'h5A, LW SW_ADDR -> ld_data_W = 32'h5A.
- Bubble and unmapped:
  - mem_wren_M=1 with insn_vld_M=0 to 0x40 -> no write.
  - LW 32'h2000_0000 -> ld_data_W = 0.
